// File: rtl/filter_test_sequencer.sv
// Stimulus sequencer that sweeps the exponential generator's overlay/rate/delay controls.
// Optional FILTER_SEQ_LOOP_EN adds i_loop so a finished sweep restarts without a DONE cycle.
module filter_test_sequencer #(
  parameter int SIZE_DELAY = 8,
  parameter int SIZE_DWELL = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
`ifdef FILTER_SEQ_LOOP_EN
  input  logic                  i_loop,
`endif
  input  logic [3:0]            i_mode_en,
  input  logic [SIZE_DELAY-1:0] i_delay_first,
  input  logic [SIZE_DELAY-1:0] i_delay_last,
  input  logic [SIZE_DELAY-1:0] i_delay_step,
  input  logic [SIZE_DWELL-1:0] i_dwell,
  output logic                  o_test_overlay,
  output logic                  o_test_rate,
  output logic [SIZE_DELAY-1:0] o_test_delay,
  output logic                  o_busy,
  output logic                  o_step_strobe,
  output logic [7:0]            o_step_index,
  output logic                  o_done
);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_DONE} state_t;

  state_t                r_state;
  logic [3:0]            r_mode_en;
  logic [SIZE_DELAY-1:0] r_first;
  logic [SIZE_DELAY-1:0] r_last;
  logic [SIZE_DELAY-1:0] r_step_eff;
  logic [SIZE_DWELL-1:0] r_dwell_eff;
  logic [SIZE_DWELL-1:0] r_cnt;
  logic [1:0]            r_mode;
  logic [SIZE_DELAY-1:0] r_delay;
  logic                  r_busy;
  logic                  r_strobe;
  logic [7:0]            r_index;
  logic                  r_done;

  logic [SIZE_DELAY-1:0] w_in_step_eff;
  logic [SIZE_DWELL-1:0] w_in_dwell_eff;
  logic [1:0]            w_in_mode;
  logic [1:0]            w_hi_mode;
  logic                  w_hi_found;
  logic [SIZE_DELAY:0]   w_next;
  logic                  w_fits;
  logic                  w_cnt_done;
  logic [7:0]            w_index_inc;

  assign w_in_step_eff  = (i_delay_step == '0) ? SIZE_DELAY'(1) : i_delay_step;
  assign w_in_dwell_eff = (i_dwell == '0) ? SIZE_DWELL'(1) : i_dwell;
  assign w_next      = {1'b0, r_delay} + {1'b0, r_step_eff};
  // Carry out of the delay width means the sweep would wrap, so treat it as past the end.
  assign w_fits      = !w_next[SIZE_DELAY] && (w_next[SIZE_DELAY-1:0] <= r_last);
  assign w_cnt_done  = (r_cnt >= r_dwell_eff);
  assign w_index_inc = (r_index == 8'hFF) ? 8'hFF : r_index + 8'd1;

  always_comb begin
    w_in_mode  = 2'd0;
    w_hi_mode  = 2'd0;
    w_hi_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (i_mode_en[k]) w_in_mode = 2'(k);
      if (r_mode_en[k] && (2'(k) > r_mode)) begin
        w_hi_mode  = 2'(k);
        w_hi_found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_mode_en   <= '0;
      r_first     <= '0;
      r_last      <= '0;
      r_step_eff  <= '0;
      r_dwell_eff <= '0;
      r_cnt       <= '0;
      r_mode      <= '0;
      r_delay     <= '0;
      r_busy      <= 1'b0;
      r_strobe    <= 1'b0;
      r_index     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_mode  <= '0;
        r_delay <= '0;
        r_busy  <= 1'b0;
        r_index <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_mode_en   <= i_mode_en;
              r_first     <= i_delay_first;
              r_last      <= i_delay_last;
              r_step_eff  <= w_in_step_eff;
              r_dwell_eff <= w_in_dwell_eff;
              if (i_mode_en == 4'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state  <= S_DWELL;
                r_mode   <= w_in_mode;
                r_delay  <= i_delay_first;
                r_cnt    <= SIZE_DWELL'(1);
                r_busy   <= 1'b1;
                r_strobe <= 1'b1;
                r_index  <= '0;
              end
            end
          end
          S_DWELL: begin
            if (!w_cnt_done) begin
              r_cnt <= r_cnt + SIZE_DWELL'(1);
            end else if (w_fits) begin
              r_delay  <= w_next[SIZE_DELAY-1:0];
              r_cnt    <= SIZE_DWELL'(1);
              r_strobe <= 1'b1;
              r_index  <= w_index_inc;
            end else if (w_hi_found) begin
              r_mode   <= w_hi_mode;
              r_delay  <= r_first;
              r_cnt    <= SIZE_DWELL'(1);
              r_strobe <= 1'b1;
              r_index  <= w_index_inc;
`ifdef FILTER_SEQ_LOOP_EN
            end else if (i_loop && (i_mode_en != 4'd0)) begin
              r_mode_en   <= i_mode_en;
              r_first     <= i_delay_first;
              r_last      <= i_delay_last;
              r_step_eff  <= w_in_step_eff;
              r_dwell_eff <= w_in_dwell_eff;
              r_mode      <= w_in_mode;
              r_delay     <= i_delay_first;
              r_cnt       <= SIZE_DWELL'(1);
              r_strobe    <= 1'b1;
              r_index     <= '0;
`endif
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_mode  <= '0;
              r_delay <= '0;
              r_busy  <= 1'b0;
              r_index <= '0;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_test_overlay = r_mode[1];
  assign o_test_rate    = r_mode[0];
  assign o_test_delay   = r_delay;
  assign o_busy         = r_busy;
  assign o_step_strobe  = r_strobe;
  assign o_step_index   = r_index;
  assign o_done         = r_done;

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Directed bench for filter_test_sequencer; outputs are packed and compared once per cycle.
module tb_filter_test_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       loop;
  logic [3:0] mode_en;
  logic [7:0] d_first, d_last, d_step;
  logic [15:0] dwell;
  logic       ov, rt, busy, strobe, done;
  logic [7:0] dly, idx;

  int n_tests = 0;
  int n_fail  = 0;

  filter_test_sequencer #(.SIZE_DELAY(8), .SIZE_DWELL(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
`ifdef FILTER_SEQ_LOOP_EN
    .i_loop(loop),
`endif
    .i_mode_en(mode_en), .i_delay_first(d_first), .i_delay_last(d_last),
    .i_delay_step(d_step), .i_dwell(dwell),
    .o_test_overlay(ov), .o_test_rate(rt), .o_test_delay(dly), .o_busy(busy),
    .o_step_strobe(strobe), .o_step_index(idx), .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic o, input logic r, input logic b,
                                     input logic s, input logic d,
                                     input logic [7:0] ix, input logic [7:0] dl);
    return {11'd0, o, r, b, s, d, ix, dl};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the current cycle's packed outputs, then advance one cycle.
  task automatic expect_cyc(input string tag, input logic [31:0] exp);
    check(tag, pk(ov, rt, busy, strobe, done, idx, dly), exp);
    tick();
  endtask

  task automatic launch(input logic [3:0] m, input logic [7:0] f, input logic [7:0] l,
                        input logic [7:0] s, input logic [15:0] dw, input bit scramble);
    mode_en = m; d_first = f; d_last = l; d_step = s; dwell = dw; start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin
      mode_en = 4'($urandom); d_first = 8'($urandom); d_last = 8'($urandom);
      d_step  = 8'($urandom); dwell = 16'($urandom_range(1, 9));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0;
    mode_en = '0; d_first = '0; d_last = '0; d_step = '0; dwell = '0;
    #1;
    check("reset_hold", pk(ov, rt, busy, strobe, done, idx, dly), 32'd0);
    #22 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) expect_cyc("idle_no_start", 32'd0);

    // Basic sweep 10..30 step 10, dwell 3; inputs scrambled after start to prove latching.
    launch(4'b0001, 8'd10, 8'd30, 8'd10, 16'd3, 1'b1);
    expect_cyc("basic_c1", pk(0, 0, 1, 1, 0, 8'd0, 8'd10));
    expect_cyc("basic_c2", pk(0, 0, 1, 0, 0, 8'd0, 8'd10));
    expect_cyc("basic_c3", pk(0, 0, 1, 0, 0, 8'd0, 8'd10));
    expect_cyc("basic_c4", pk(0, 0, 1, 1, 0, 8'd1, 8'd20));
    expect_cyc("basic_c5", pk(0, 0, 1, 0, 0, 8'd1, 8'd20));
    expect_cyc("basic_c6", pk(0, 0, 1, 0, 0, 8'd1, 8'd20));
    expect_cyc("basic_c7", pk(0, 0, 1, 1, 0, 8'd2, 8'd30));
    expect_cyc("basic_c8", pk(0, 0, 1, 0, 0, 8'd2, 8'd30));
    expect_cyc("basic_c9", pk(0, 0, 1, 0, 0, 8'd2, 8'd30));
    expect_cyc("basic_done", pk(0, 0, 0, 0, 1, 8'd0, 8'd0));
    expect_cyc("basic_idle", 32'd0);

    // Modes 1 and 3, single delay 5, dwell 2.
    launch(4'b1010, 8'd5, 8'd5, 8'd1, 16'd2, 1'b1);
    expect_cyc("mode_c1", pk(0, 1, 1, 1, 0, 8'd0, 8'd5));
    expect_cyc("mode_c2", pk(0, 1, 1, 0, 0, 8'd0, 8'd5));
    expect_cyc("mode_c3", pk(1, 1, 1, 1, 0, 8'd1, 8'd5));
    expect_cyc("mode_c4", pk(1, 1, 1, 0, 0, 8'd1, 8'd5));
    expect_cyc("mode_done", pk(0, 0, 0, 0, 1, 8'd0, 8'd0));

    // No wrap past 255.
    launch(4'b0001, 8'd250, 8'd255, 8'd4, 16'd1, 1'b1);
    expect_cyc("wrap_c1", pk(0, 0, 1, 1, 0, 8'd0, 8'd250));
    expect_cyc("wrap_c2", pk(0, 0, 1, 1, 0, 8'd1, 8'd254));
    expect_cyc("wrap_done", pk(0, 0, 0, 0, 1, 8'd0, 8'd0));

    // step=0 and dwell=0 behave as 1.
    launch(4'b0001, 8'd1, 8'd3, 8'd0, 16'd0, 1'b1);
    expect_cyc("zero_c1", pk(0, 0, 1, 1, 0, 8'd0, 8'd1));
    expect_cyc("zero_c2", pk(0, 0, 1, 1, 0, 8'd1, 8'd2));
    expect_cyc("zero_c3", pk(0, 0, 1, 1, 0, 8'd2, 8'd3));
    expect_cyc("zero_done", pk(0, 0, 0, 0, 1, 8'd0, 8'd0));

    // last < first: one point per mode at first, no gap across the mode change.
    launch(4'b0011, 8'd20, 8'd10, 8'd1, 16'd1, 1'b1);
    expect_cyc("rev_c1", pk(0, 0, 1, 1, 0, 8'd0, 8'd20));
    expect_cyc("rev_c2", pk(0, 1, 1, 1, 0, 8'd1, 8'd20));
    expect_cyc("rev_done", pk(0, 0, 0, 0, 1, 8'd0, 8'd0));

    // No modes enabled: done next cycle, busy never high.
    launch(4'b0000, 8'd1, 8'd2, 8'd1, 16'd1, 1'b1);
    expect_cyc("nomode_done", pk(0, 0, 0, 0, 1, 8'd0, 8'd0));
    expect_cyc("nomode_idle", 32'd0);

    // Abort in cycle 4, restart in cycle 5, mid-sweep start ignored.
    launch(4'b0001, 8'd10, 8'd30, 8'd10, 16'd3, 1'b0);
    expect_cyc("abt_c1", pk(0, 0, 1, 1, 0, 8'd0, 8'd10));
    expect_cyc("abt_c2", pk(0, 0, 1, 0, 0, 8'd0, 8'd10));
    expect_cyc("abt_c3", pk(0, 0, 1, 0, 0, 8'd0, 8'd10));
    abort = 1'b1;
    expect_cyc("abt_c4", pk(0, 0, 1, 1, 0, 8'd1, 8'd20));
    abort = 1'b0;
    start = 1'b1;
    expect_cyc("abt_c5", 32'd0);
    start = 1'b0;
    expect_cyc("rep_c1", pk(0, 0, 1, 1, 0, 8'd0, 8'd10));
    start = 1'b1; mode_en = 4'b1111; d_first = 8'd99; dwell = 16'd1;
    expect_cyc("rep_c2", pk(0, 0, 1, 0, 0, 8'd0, 8'd10));
    start = 1'b0;
    expect_cyc("rep_c3", pk(0, 0, 1, 0, 0, 8'd0, 8'd10));
    expect_cyc("rep_c4", pk(0, 0, 1, 1, 0, 8'd1, 8'd20));
    expect_cyc("rep_c5", pk(0, 0, 1, 0, 0, 8'd1, 8'd20));
    expect_cyc("rep_c6", pk(0, 0, 1, 0, 0, 8'd1, 8'd20));
    expect_cyc("rep_c7", pk(0, 0, 1, 1, 0, 8'd2, 8'd30));
    expect_cyc("rep_c8", pk(0, 0, 1, 0, 0, 8'd2, 8'd30));
    expect_cyc("rep_c9", pk(0, 0, 1, 0, 0, 8'd2, 8'd30));
    expect_cyc("rep_done", pk(0, 0, 0, 0, 1, 8'd0, 8'd0));

    // Asynchronous reset mid-sweep clears outputs without a done.
    launch(4'b0001, 8'd10, 8'd30, 8'd10, 16'd3, 1'b1);
    expect_cyc("rst_c1", pk(0, 0, 1, 1, 0, 8'd0, 8'd10));
    #2 rst_n = 1'b0;
    #1 check("rst_async", pk(ov, rt, busy, strobe, done, idx, dly), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    expect_cyc("rst_after1", 32'd0);
    expect_cyc("rst_after2", 32'd0);

`ifdef FILTER_SEQ_LOOP_EN
    // Loop: second pass follows directly, then loop dropped yields done.
    loop = 1'b1;
    launch(4'b0001, 8'd10, 8'd30, 8'd10, 16'd3, 1'b0);
    for (int c = 0; c < 9; c++)
      expect_cyc("loop_p1", pk(0, 0, 1, (c % 3) == 0, 0, 8'(c / 3), 8'(10 + 10 * (c / 3))));
    expect_cyc("loop_restart", pk(0, 0, 1, 1, 0, 8'd0, 8'd10));
    loop = 1'b0;
    for (int c = 1; c < 9; c++)
      expect_cyc("loop_p2", pk(0, 0, 1, (c % 3) == 0, 0, 8'(c / 3), 8'(10 + 10 * (c / 3))));
    expect_cyc("loop_done", pk(0, 0, 0, 0, 1, 8'd0, 8'd0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
